// File: rtl/centroid_update.sv
// centroid_update: per-class sum/count accumulation over one k-means epoch,
// followed by a shared restoring divider that produces the new centroid of
// every class in index order over a valid/ready output handshake.
module centroid_update #(
    parameter int n   = 8,
    parameter int DIM = 2,
    parameter int W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIM*W-1:0]   in_point,
    input  logic [31:0]        in_class,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_class,
    output logic [DIM*W-1:0]   out_centroid,
    output logic [31:0]        out_count,
    output logic               out_last,
    output logic               busy
);

    localparam int NC = 2 ** n;
    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Accumulator storage
    logic [63:0]        r_sum [NC][DIM];
    logic [31:0]        r_cnt [NC];

    // Divider / sequencing state
    logic [n-1:0]       r_k;
    logic [5:0]         r_bit;
    logic [CW-1:0]      r_coord;
    logic [31:0]        r_rem;
    logic [63:0]        r_quo;
    logic [DIM*W-1:0]   r_cent_acc;

    // Registered outputs
    logic               r_out_valid;
    logic [31:0]        r_out_class;
    logic [DIM*W-1:0]   r_out_centroid;
    logic [31:0]        r_out_count;
    logic               r_out_last;

    // Combinational helpers
    logic               w_in_ready;
    logic               w_accept;
    logic [n-1:0]       w_class;
    logic [31:0]        w_cnt_k;
    logic               w_empty;
    logic [63:0]        w_dvd_src;
    logic [31:0]        w_rem_src;
    logic [32:0]        w_trial;
    logic               w_ge;
    logic [31:0]        w_rem_next;
    logic [63:0]        w_quo_next;
    logic               w_coord_done;
    logic               w_last_coord;
    logic               w_div_done;
    logic               w_handshake;
    logic               w_k_last;
    logic [DIM*W-1:0]   w_cent_final;
    logic               w_unused_class_bits;

    // Upper class-index bits are intentionally ignored
    assign w_unused_class_bits = ^in_class[31:n];

    assign w_in_ready   = (r_state == ST_ACCUM) & ~rst;
    assign w_accept     = in_valid & w_in_ready;
    assign w_class      = in_class[n-1:0];
    assign w_cnt_k      = r_cnt[r_k];
    assign w_empty      = (w_cnt_k == 32'd0);
    assign w_coord_done = (r_bit == 6'd63);
    assign w_last_coord = (r_coord == CW'(DIM - 1));
    assign w_div_done   = w_empty | (w_coord_done & w_last_coord);
    assign w_handshake  = r_out_valid & out_ready;
    assign w_k_last     = (r_k == {n{1'b1}});

    // One restoring-division step; the first step of a coordinate loads the
    // dividend straight from the sum store so each coordinate costs 64 cycles.
    always_comb begin
        w_dvd_src    = r_quo;
        w_rem_src    = r_rem;
        w_trial      = 33'd0;
        w_ge         = 1'b0;
        w_rem_next   = 32'd0;
        w_quo_next   = 64'd0;
        w_cent_final = r_cent_acc;
        if (r_bit == 6'd0) begin
            w_dvd_src = r_sum[r_k][r_coord];
            w_rem_src = 32'd0;
        end else begin
            w_dvd_src = r_quo;
            w_rem_src = r_rem;
        end
        w_trial = {w_rem_src, w_dvd_src[63]};
        // Remainder stays below the divisor, so a 32-bit difference is exact
        w_ge = w_trial[32] | (w_trial[31:0] >= w_cnt_k);
        if (w_ge) begin
            w_rem_next = w_trial[31:0] - w_cnt_k;
        end else begin
            w_rem_next = w_trial[31:0];
        end
        w_quo_next = {w_dvd_src[62:0], w_ge};
        w_cent_final[r_coord*W +: W] = w_quo_next[W-1:0];
    end

    // Next-state decode for the accumulate / divide / emit sequence
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && in_last) begin
                    w_state_next = ST_DIVIDE;
                end else begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_DIVIDE: begin
                if (w_div_done) begin
                    w_state_next = ST_EMIT;
                end else begin
                    w_state_next = ST_DIVIDE;
                end
            end
            ST_EMIT: begin
                if (w_handshake && w_k_last) begin
                    w_state_next = ST_ACCUM;
                end else if (w_handshake) begin
                    w_state_next = ST_DIVIDE;
                end else begin
                    w_state_next = ST_EMIT;
                end
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Accumulators, divider registers and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                r_cnt[c] <= 32'd0;
                for (int d = 0; d < DIM; d++) begin
                    r_sum[c][d] <= 64'd0;
                end
            end
            r_k            <= {n{1'b0}};
            r_bit          <= 6'd0;
            r_coord        <= {CW{1'b0}};
            r_rem          <= 32'd0;
            r_quo          <= 64'd0;
            r_cent_acc     <= {(DIM*W){1'b0}};
            r_out_valid    <= 1'b0;
            r_out_class    <= 32'd0;
            r_out_centroid <= {(DIM*W){1'b0}};
            r_out_count    <= 32'd0;
            r_out_last     <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        for (int d = 0; d < DIM; d++) begin
                            r_sum[w_class][d] <= r_sum[w_class][d] + 64'(in_point[d*W +: W]);
                        end
                        r_cnt[w_class] <= r_cnt[w_class] + 32'd1;
                        if (in_last) begin
                            r_k     <= {n{1'b0}};
                            r_bit   <= 6'd0;
                            r_coord <= {CW{1'b0}};
                        end
                    end
                end
                ST_DIVIDE: begin
                    if (w_empty) begin
                        r_out_valid    <= 1'b1;
                        r_out_class    <= 32'(r_k);
                        r_out_centroid <= {(DIM*W){1'b0}};
                        r_out_count    <= 32'd0;
                        r_out_last     <= w_k_last;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_bit <= r_bit + 6'd1;
                        if (w_coord_done && w_last_coord) begin
                            r_coord        <= {CW{1'b0}};
                            r_out_valid    <= 1'b1;
                            r_out_class    <= 32'(r_k);
                            r_out_centroid <= w_cent_final;
                            r_out_count    <= w_cnt_k;
                            r_out_last     <= w_k_last;
                        end else if (w_coord_done) begin
                            r_coord    <= r_coord + CW'(1);
                            r_cent_acc <= w_cent_final;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        r_cnt[r_k]  <= 32'd0;
                        for (int d = 0; d < DIM; d++) begin
                            r_sum[r_k][d] <= 64'd0;
                        end
                        r_bit   <= 6'd0;
                        r_coord <= {CW{1'b0}};
                        if (!w_k_last) begin
                            r_k <= r_k + {{(n-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign out_class    = r_out_class;
    assign out_centroid = r_out_centroid;
    assign out_count    = r_out_count;
    assign out_last     = r_out_last;
    assign busy         = (r_state != ST_ACCUM);

endmodule

// File: tb/tb_centroid_update.sv
// Directed bench for centroid_update with four classes (n=2), DIM=2, W=32.
module tb_centroid_update;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_point;
    logic [31:0] in_class;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_class;
    logic [63:0] out_centroid;
    logic [31:0] out_count;
    logic        out_last;
    logic        busy;

    int checks;
    int errors;
    int nw;
    int seen_valid;
    logic [63:0] held_cent;

    centroid_update #(.n(2), .DIM(2), .W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_point     (in_point),
        .in_class     (in_class),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_class    (out_class),
        .out_centroid (out_centroid),
        .out_count    (out_count),
        .out_last     (out_last),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] cls, input logic last);
        in_valid = 1'b1;
        in_point = {y, x};
        in_class = cls;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (out_valid !== 1'b1 && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
    endtask

    // Wait for a result, check every field, then complete the handshake
    task automatic get_result(input string tag, input logic [31:0] cls,
                              input logic [31:0] c0, input logic [31:0] c1,
                              input logic [31:0] cnt, input logic last,
                              output int waited);
        wait_valid(waited);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_class"}, {32'd0, out_class}, {32'd0, cls});
        chk({tag, "_cent"},  out_centroid, {c1, c0});
        chk({tag, "_count"}, {32'd0, out_count}, {32'd0, cnt});
        chk({tag, "_last"},  {63'd0, out_last}, {63'd0, last});
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_point  = 64'd0;
        in_class  = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        chk("rst_class",     {32'd0, out_class}, 64'd0);
        chk("rst_count",     {32'd0, out_count}, 64'd0);
        chk("rst_cent",      out_centroid,       64'd0);
        chk("rst_last",      {63'd0, out_last},  64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // in_last without in_valid must be ignored
        in_last = 1'b1;
        @(posedge clk); #1;
        in_last = 1'b0;
        chk("lone_last_busy",  {63'd0, busy},     64'd0);
        chk("lone_last_ready", {63'd0, in_ready}, 64'd1);

        // Basic epoch
        send(32'd10, 32'd20, 32'd1, 1'b0);
        send(32'd30, 32'd40, 32'd1, 1'b0);
        send(32'd5,  32'd5,  32'd3, 1'b1);
        chk("basic_busy",     {63'd0, busy},     64'd1);
        chk("basic_in_ready", {63'd0, in_ready}, 64'd0);
        get_result("b0", 32'd0, 32'd0,  32'd0,  32'd0, 1'b0, nw);
        get_result("b1", 32'd1, 32'd20, 32'd30, 32'd2, 1'b0, nw);
        get_result("b2", 32'd2, 32'd0,  32'd0,  32'd0, 1'b0, nw);
        get_result("b3", 32'd3, 32'd5,  32'd5,  32'd1, 1'b1, nw);
        chk("basic_done_ready", {63'd0, in_ready},  64'd1);
        chk("basic_done_busy",  {63'd0, busy},      64'd0);
        chk("basic_done_valid", {63'd0, out_valid}, 64'd0);

        // Second epoch: isolation plus backpressure on class 1
        send(32'd2, 32'd4, 32'd1, 1'b1);
        get_result("i0", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, nw);
        out_ready = 1'b0;
        wait_valid(nw);
        chk("bp_arrive", {63'd0, out_valid}, 64'd1);
        held_cent = out_centroid;
        chk("bp_cent0", held_cent, {32'd4, 32'd2});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_class", {32'd0, out_class}, 64'd1);
            chk("bp_cent",  out_centroid,       {32'd4, 32'd2});
            chk("bp_count", {32'd0, out_count}, 64'd1);
            chk("bp_last",  {63'd0, out_last},  64'd0);
            chk("bp_ready", {63'd0, in_ready},  64'd0);
        end
        get_result("i1", 32'd1, 32'd2, 32'd4, 32'd1, 1'b0, nw);
        chk("i1_valid_drop", {63'd0, out_valid}, 64'd0);
        get_result("i2", 32'd2, 32'd0, 32'd0, 32'd0, 1'b0, nw);
        chk("i2_wait", nw, 64'd1);
        get_result("i3", 32'd3, 32'd0, 32'd0, 32'd0, 1'b1, nw);

        // Truncating division and class-index masking
        send(32'd7, 32'd0, 32'd1, 1'b0);
        send(32'd8, 32'd0, 32'd5, 1'b1);
        get_result("t0", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, nw);
        get_result("t1", 32'd1, 32'd7, 32'd0, 32'd2, 1'b0, nw);
        get_result("t2", 32'd2, 32'd0, 32'd0, 32'd0, 1'b0, nw);
        get_result("t3", 32'd3, 32'd0, 32'd0, 32'd0, 1'b1, nw);

        // Latency of a populated class and of an empty class
        send(32'd9, 32'd9, 32'd0, 1'b1);
        chk("lat_busy", {63'd0, busy}, 64'd1);
        get_result("l0", 32'd0, 32'd9, 32'd9, 32'd1, 1'b0, nw);
        chk("lat_class0_cycles", nw, 64'd128);
        get_result("l1", 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, nw);
        chk("lat_class1_cycles", nw, 64'd1);
        get_result("l2", 32'd2, 32'd0, 32'd0, 32'd0, 1'b0, nw);
        get_result("l3", 32'd3, 32'd0, 32'd0, 32'd0, 1'b1, nw);

        // Reset in the middle of DIVIDE aborts the epoch
        send(32'd1, 32'd1, 32'd0, 1'b1);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_busy",  {63'd0, busy},      64'd0);
        chk("abort_ready", {63'd0, in_ready},  64'd1);
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        seen_valid = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen_valid++;
        end
        chk("abort_no_output", seen_valid, 64'd0);
        send(32'd6, 32'd6, 32'd2, 1'b1);
        get_result("r0", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, nw);
        get_result("r1", 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, nw);
        get_result("r2", 32'd2, 32'd6, 32'd6, 32'd1, 1'b0, nw);
        get_result("r3", 32'd3, 32'd0, 32'd0, 32'd0, 1'b1, nw);
        chk("final_ready", {63'd0, in_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/centroid_update.md
Name: centroid_update

Overview:
- Downstream of the argmin stage in the k-means datapath.
- Consumes a stream of (point, winning class index) pairs and accumulates a per-class coordinate sum and point count over one epoch.
- On the epoch's last point it divides sum by count for every class with one shared sequential divider, then emits the new centroids one class at a time over a valid/ready handshake.
- Accumulators clear as each class is emitted, ready for the next epoch.

Parameters:
- n, 8, number of classes is 2**n; the class index is taken from in_class[n-1:0].
- DIM, 2, number of coordinates per point.
- W, 32, unsigned coordinate width.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  point/class pair valid.
- in_ready  output  1  block accepts a point this cycle.
- in_point  input  DIM*W  coordinates; coordinate d is in_point[d*W +: W].
- in_class  input  32  class index from the argmin stage; bits above n-1 are ignored.
- in_last  input  1  marks the final point of the epoch.
- out_valid  output  1  centroid result valid.
- out_ready  input  1  consumer accepts the result.
- out_class  output  32  class index of the result, zero-extended.
- out_centroid  output  DIM*W  new centroid, same packing as in_point.
- out_count  output  32  number of points accumulated for this class.
- out_last  output  1  high with the result for class 2**n-1.
- busy  output  1  high in DIVIDE or EMIT.

Behaviour:
- Storage per class c and coordinate d:
  - sum[c][d] is 64 bits, unsigned, wraps modulo 2**64.
  - cnt[c] is 32 bits, wraps modulo 2**32; overflow is not a supported operating point.
- Reset (rst=1 at a clock edge):
  - state=ACCUM, all sum and cnt cleared, class pointer k=0.
  - out_valid=0, out_class=0, out_centroid=0, out_count=0, out_last=0, busy=0.
  - in_ready=0 while rst is high and 1 from the first cycle after rst falls.
- Reset mid-operation (DIVIDE or EMIT) aborts the epoch. No further results from that epoch are emitted; all accumulators are cleared.
- State ACCUM:
  - in_ready=1.
  - On in_valid & in_ready: sum[c][d] += zero-extended in_point[d], and cnt[c] += 1, where c = in_class[n-1:0].
  - If in_last is also high: that point is included, k=0, go to DIVIDE next cycle.
  - in_last without in_valid has no effect.
- State DIVIDE (for class k):
  - in_ready=0.
  - If cnt[k]==0: lasts exactly 1 cycle; result centroid=0, count=0.
  - Else: restoring division, one quotient bit per cycle, coordinates in order d=0..DIM-1.
  - Each coordinate takes exactly 64 cycles, so the class takes exactly DIM*64 cycles.
  - quotient = floor(sum[k][d] / cnt[k]), 64-bit; the low W bits are the centroid coordinate.
  - The quotient never exceeds the largest input coordinate, so truncation is lossless.
  - Then go to EMIT.
- State EMIT:
  - out_valid=1; out_class=k, out_centroid, out_count=cnt[k], and out_last=(k==2**n-1) are registered.
  - Outputs are held stable until out_valid & out_ready.
  - On the handshake cycle:
    - sum[k][*] and cnt[k] are cleared.
    - If k==2**n-1: next state ACCUM, out_valid=0.
    - Else: k+=1, next state DIVIDE, out_valid=0.
- Timing, with in_last accepted at cycle t:
  - DIVIDE for class 0 starts at t+1.
  - out_valid for class 0 rises at t+1+D0, where D0=DIM*64 if cnt[0]>0 and D0=1 otherwise.
  - Each later class's DIVIDE starts the cycle after the previous EMIT handshake.
- Classes are always emitted in order 0..2**n-1, including empty classes, so the consumer can keep the previous centroid when out_count==0.
- Accepting points is impossible outside ACCUM, so simultaneous accumulate and clear cannot occur.

Test Plan:
- Basic epoch (n=2, DIM=2, out_ready=1): feed (10,20) class1, (30,40) class1, (5,5) class3 with in_last.
  - Required: four results.
    - class0: (0,0), count 0.
    - class1: (20,30), count 2.
    - class2: (0,0), count 0.
    - class3: (5,5), count 1, out_last=1.
  - in_ready returns to 1 after the class3 handshake.
- Truncation and index masking (n=2): (7,0) with in_class=1 and (8,0) with in_class=5 (maps to 1), last.
  - Required: class1 = (7,0), count 2.
- Latency (n=2, DIM=2): single point (9,9) class0 with in_last at cycle t.
  - Required: out_valid rises at exactly t+129, busy=1 from t+1.
  - Class1 result appears 2 cycles after the class0 handshake (1-cycle empty DIVIDE plus registration).
- Backpressure: hold out_ready=0 for 10 cycles during class1 EMIT.
  - Required: out_valid stays 1, all out_* stable, in_ready stays 0.
  - Class2 follows only after the handshake.
- Epoch isolation: run the basic epoch, then a second epoch with (2,4) class1, last.
  - Required: class1 = (2,4), count 1; all other classes count 0.
- Reset mid-DIVIDE: assert rst for 1 cycle 20 cycles after in_last.
  - Required: out_valid never rises, busy=0 and in_ready=1 the cycle after rst falls.
  - A following epoch with (6,6) class2 yields only class2 count 1.
